// File: rtl/instruction_fetcher.sv
// Byte-serial instruction fetch: assembles little-endian words from an
// 8-bit memory port and queues them with their PC for the decoder.
module instruction_fetcher #(
   parameter int          DEPTH_LOG = 2,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_grant,
   output logic [31:0] mem_a,
   output logic        mem_rd_en,
   input  logic [7:0]  mem_din,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        inst_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG+1:0] DEPTH_W = (DEPTH_LOG+2)'(DEPTH);

   logic [31:0]          fetch_pc_q, fetch_pc_d;
   logic [1:0]           req_k_q, req_k_d;
   logic [1:0]           rcv_k_q, rcv_k_d;
   logic                 resp_pending_q, resp_pending_d;
   logic [23:0]          asm_word_q, asm_word_d;
   logic [31:0]          asm_pc_q, asm_pc_d;
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [31:0]          fifo_word_q [DEPTH];
   logic [31:0]          fifo_pc_q   [DEPTH];

   logic                 in_asm;
   logic [DEPTH_LOG+1:0] occ;
   logic                 can_issue;
   logic                 push;
   logic                 pop;
   logic                 push_en;

   always_comb begin
      // A started word reserves a queue slot until it is pushed.
      in_asm    = resp_pending_q | (rcv_k_q != 2'd0) | (req_k_q != 2'd0);
      occ       = {1'b0, count_q} + (DEPTH_LOG+2)'(in_asm);
      can_issue = (req_k_q != 2'd0) | (occ < DEPTH_W);
      mem_rd_en = !rst & !redirect_valid & mem_grant & can_issue;
      mem_a     = fetch_pc_q + {30'd0, req_k_q};

      inst_valid = !rst & (count_q != '0);
      inst       = rst ? 32'd0 : fifo_word_q[rd_ptr_q];
      inst_pc    = rst ? 32'd0 : fifo_pc_q[rd_ptr_q];

      push    = resp_pending_q & (rcv_k_q == 2'd3);
      pop     = inst_valid & inst_ready;
      push_en = push & !redirect_valid;

      fetch_pc_d     = fetch_pc_q;
      req_k_d        = req_k_q;
      rcv_k_d        = rcv_k_q;
      resp_pending_d = mem_rd_en;
      asm_word_d     = asm_word_q;
      asm_pc_d       = asm_pc_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;

      if (mem_rd_en) begin
         req_k_d = req_k_q + 2'd1;
         if (req_k_q == 2'd0) asm_pc_d = fetch_pc_q;
         if (req_k_q == 2'd3) fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (resp_pending_q) begin
         rcv_k_d = rcv_k_q + 2'd1;
         case (rcv_k_q)
            2'd0:    asm_word_d[7:0]   = mem_din;
            2'd1:    asm_word_d[15:8]  = mem_din;
            2'd2:    asm_word_d[23:16] = mem_din;
            default: ;
         endcase
      end

      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
      if (push && !pop) count_d = count_q + (DEPTH_LOG+1)'(1);
      if (pop && !push) count_d = count_q - (DEPTH_LOG+1)'(1);

      if (redirect_valid) begin
         fetch_pc_d     = redirect_pc;
         req_k_d        = 2'd0;
         rcv_k_d        = 2'd0;
         resp_pending_d = 1'b0;
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         count_d        = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q     <= RESET_PC;
         req_k_q        <= 2'd0;
         rcv_k_q        <= 2'd0;
         resp_pending_q <= 1'b0;
         asm_word_q     <= 24'd0;
         asm_pc_q       <= 32'd0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         fetch_pc_q     <= fetch_pc_d;
         req_k_q        <= req_k_d;
         rcv_k_q        <= rcv_k_d;
         resp_pending_q <= resp_pending_d;
         asm_word_q     <= asm_word_d;
         asm_pc_q       <= asm_pc_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_en) begin
         fifo_word_q[wr_ptr_q] <= {mem_din, asm_word_q};
         fifo_pc_q[wr_ptr_q]   <= asm_pc_q;
      end
   end

endmodule
